// File: rtl/adc_sched_pkg.sv
// Shared types and width helpers for the ADC conversion scheduler.
package adc_sched_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CONV      = 2'd1,
    WAIT_BUSY = 2'd2,
    READ      = 2'd3
  } sched_state_t;

  function automatic int ch_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  // Timer must hold both the CONVST width and the BUSY timeout count.
  function automatic int tmr_w(input int convst_cycles, input int busy_timeout);
    int m;
    m = (convst_cycles > busy_timeout) ? convst_cycles : busy_timeout;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/adc_conv_scheduler_if.sv
// Trigger/ADC/reader signal bundle of the conversion scheduler.
interface adc_conv_scheduler_if
  import adc_sched_pkg::*;
#(
  parameter int NUM_CH   = 8,
  parameter int TS_WIDTH = 32
) ();

  localparam int CH_W = ch_w(NUM_CH);

  logic                TRIG;
  logic                BUSY;
  logic                RD_ACK;
  logic                CONVST;
  logic                RD_REQ;
  logic [CH_W-1:0]     CH_SEL;
  logic                SAMPLE_DONE;
  logic                OVERRUN;
  logic                TIMEOUT;
  logic [TS_WIDTH-1:0] TIMESTAMP;

  modport master (
    input  TRIG, BUSY, RD_ACK,
    output CONVST, RD_REQ, CH_SEL, SAMPLE_DONE, OVERRUN, TIMEOUT, TIMESTAMP
  );

  modport slave (
    output TRIG, BUSY, RD_ACK,
    input  CONVST, RD_REQ, CH_SEL, SAMPLE_DONE, OVERRUN, TIMEOUT, TIMESTAMP
  );

endinterface

// File: rtl/adc_sched_timer.sv
// Loadable saturating up-counter with terminal-count compare, shared by CONV and WAIT_BUSY.
module adc_sched_timer #(
  parameter int W = 9
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         load,
  input  logic [W-1:0] tc_val,
  output logic [W-1:0] count,
  output logic         tc
);

  logic [W-1:0] count_r;

  // Count up from zero after a load, holding at all-ones
  always_ff @(posedge CLK) begin
    if (RST) begin
      count_r <= {W{1'b0}};
    end else if (load) begin
      count_r <= {W{1'b0}};
    end else if (count_r != {W{1'b1}}) begin
      count_r <= count_r + W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;
  assign tc    = (count_r == tc_val);

endmodule

// File: rtl/adc_conv_scheduler.sv
// One multi-channel ADC conversion per TRIG rising edge: CONVST, BUSY wait, REQ/ACK channel reads.
// Optional ADC_SCHED_TIMESTAMP_EN adds a free-running trigger timestamp on TIMESTAMP.
module adc_conv_scheduler
  import adc_sched_pkg::*;
#(
  parameter int NUM_CH        = 8,
  parameter int CONVST_CYCLES = 4,
  parameter int BUSY_MASK     = 2,
  parameter int BUSY_TIMEOUT  = 400,
  parameter int TS_WIDTH      = 32
) (
  input logic                  CLK,
  input logic                  RST,
  adc_conv_scheduler_if.master bus
);

  localparam int CH_W  = ch_w(NUM_CH);
  localparam int TMR_W = tmr_w(CONVST_CYCLES, BUSY_TIMEOUT);

  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CH - 1);
  localparam logic [TMR_W-1:0] CONV_TC  = TMR_W'(CONVST_CYCLES - 1);
  localparam logic [TMR_W-1:0] BUSY_TC  = TMR_W'(BUSY_TIMEOUT);
  localparam logic [TMR_W-1:0] MASK_END = TMR_W'(BUSY_MASK);

  sched_state_t     state_r, state_nxt_s;
  logic             trig_q_r;
  logic             trig_edge_s;
  logic             xfer_s;
  logic [CH_W-1:0]  ch_r, ch_nxt_s;
  logic             convst_r, convst_nxt_s;
  logic             rd_req_r, rd_req_nxt_s;
  logic             done_r, done_nxt_s;
  logic             ovr_r, ovr_nxt_s;
  logic             tmo_r, tmo_nxt_s;
  logic             tmr_load_s;
  logic [TMR_W-1:0] tmr_tc_val_s;
  logic [TMR_W-1:0] tmr_cnt_s;
  logic             tmr_tc_s;

  assign trig_edge_s = bus.TRIG & ~trig_q_r;
  assign xfer_s      = rd_req_r & bus.RD_ACK;
  assign tmr_load_s  = (state_nxt_s != state_r) || (state_r == IDLE);

  adc_sched_timer #(.W(TMR_W)) u_timer (
    .CLK    (CLK),
    .RST    (RST),
    .load   (tmr_load_s),
    .tc_val (tmr_tc_val_s),
    .count  (tmr_cnt_s),
    .tc     (tmr_tc_s)
  );

  // Next-state and next-output logic; an edge outside IDLE only raises OVERRUN
  always_comb begin
    state_nxt_s  = state_r;
    ch_nxt_s     = ch_r;
    convst_nxt_s = 1'b0;
    rd_req_nxt_s = 1'b0;
    done_nxt_s   = 1'b0;
    tmo_nxt_s    = 1'b0;
    ovr_nxt_s    = trig_edge_s && (state_r != IDLE);
    tmr_tc_val_s = CONV_TC;
    case (state_r)
      IDLE: begin
        ch_nxt_s = {CH_W{1'b0}};
        if (trig_edge_s) begin
          state_nxt_s  = CONV;
          convst_nxt_s = 1'b1;
        end else begin
          state_nxt_s  = IDLE;
        end
      end
      CONV: begin
        tmr_tc_val_s = CONV_TC;
        if (tmr_tc_s) begin
          state_nxt_s  = WAIT_BUSY;
        end else begin
          convst_nxt_s = 1'b1;
        end
      end
      WAIT_BUSY: begin
        tmr_tc_val_s = BUSY_TC;
        if ((tmr_cnt_s >= MASK_END) && !bus.BUSY) begin
          state_nxt_s  = READ;
          rd_req_nxt_s = 1'b1;
          ch_nxt_s     = {CH_W{1'b0}};
        end else if (tmr_tc_s) begin
          state_nxt_s  = IDLE;
          tmo_nxt_s    = 1'b1;
        end else begin
          state_nxt_s  = WAIT_BUSY;
        end
      end
      READ: begin
        if (xfer_s) begin
          if (ch_r == CH_LAST) begin
            state_nxt_s  = IDLE;
            done_nxt_s   = 1'b1;
            ch_nxt_s     = {CH_W{1'b0}};
          end else begin
            ch_nxt_s     = ch_r + CH_W'(1);
            rd_req_nxt_s = 1'b1;
          end
        end else begin
          rd_req_nxt_s = 1'b1;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Trigger history loads even under reset so a level held through reset gives no edge
  always_ff @(posedge CLK) begin
    trig_q_r <= bus.TRIG;
  end

  // State and registered outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r  <= IDLE;
      ch_r     <= {CH_W{1'b0}};
      convst_r <= 1'b0;
      rd_req_r <= 1'b0;
      done_r   <= 1'b0;
      ovr_r    <= 1'b0;
      tmo_r    <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      ch_r     <= ch_nxt_s;
      convst_r <= convst_nxt_s;
      rd_req_r <= rd_req_nxt_s;
      done_r   <= done_nxt_s;
      ovr_r    <= ovr_nxt_s;
      tmo_r    <= tmo_nxt_s;
    end
  end

  assign bus.CONVST      = convst_r;
  assign bus.RD_REQ      = rd_req_r;
  assign bus.CH_SEL      = ch_r;
  assign bus.SAMPLE_DONE = done_r;
  assign bus.OVERRUN     = ovr_r;
  assign bus.TIMEOUT     = tmo_r;

`ifdef ADC_SCHED_TIMESTAMP_EN
  logic                accept_s;
  logic [TS_WIDTH-1:0] ts_cnt_r, ts_cap_r, ts_out_r;

  assign accept_s = trig_edge_s && (state_r == IDLE);

  // Free-running stamp, captured on accept and published with SAMPLE_DONE
  always_ff @(posedge CLK) begin
    if (RST) begin
      ts_cnt_r <= {TS_WIDTH{1'b0}};
      ts_cap_r <= {TS_WIDTH{1'b0}};
      ts_out_r <= {TS_WIDTH{1'b0}};
    end else begin
      ts_cnt_r <= ts_cnt_r + TS_WIDTH'(1);
      if (accept_s) begin
        ts_cap_r <= ts_cnt_r;
      end
      if (done_nxt_s) begin
        ts_out_r <= ts_cap_r;
      end
    end
  end

  assign bus.TIMESTAMP = ts_out_r;
`else
  assign bus.TIMESTAMP = {TS_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_adc_conv_scheduler.sv
// Directed bench for adc_conv_scheduler; TIMESTAMP expectations follow ADC_SCHED_TIMESTAMP_EN.
module tb_adc_conv_scheduler;

  logic CLK = 1'b0;
  logic RST;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   n_fail = 0;
  int   xfers;
  int   e;
  int   ts_exp;

  always #5 CLK = ~CLK;

  adc_conv_scheduler_if #(.NUM_CH(8), .TS_WIDTH(4)) bus ();

  adc_conv_scheduler #(
    .NUM_CH(8), .CONVST_CYCLES(4), .BUSY_MASK(2), .BUSY_TIMEOUT(400), .TS_WIDTH(4)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  task automatic chk(input string tag, input int c, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, c, obs, exp);
    end
  endtask

  task automatic chk_cyc(input string tag, input int c, input bit convst, input bit req,
                         input int ch, input bit done, input bit ovr, input bit tmo);
    chk({tag, ".convst"}, c, 32'(bus.CONVST), 32'(convst));
    chk({tag, ".rd_req"}, c, 32'(bus.RD_REQ), 32'(req));
    if (req) chk({tag, ".ch_sel"}, c, 32'(bus.CH_SEL), 32'(ch));
    chk({tag, ".done"}, c, 32'(bus.SAMPLE_DONE), 32'(done));
    chk({tag, ".overrun"}, c, 32'(bus.OVERRUN), 32'(ovr));
    chk({tag, ".timeout"}, c, 32'(bus.TIMEOUT), 32'(tmo));
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input bit trig, input bit busy, input bit ack);
    bus.TRIG   = trig;
    bus.BUSY   = busy;
    bus.RD_ACK = ack;
  endtask

  initial begin
    // Reset with TRIG high: no edge may follow
    RST = 1'b1;
    drive(1'b1, 1'b0, 1'b0);
    repeat (3) tick();
    chk_cyc("reset", 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    chk("reset.ts", 0, 32'(bus.TIMESTAMP), 32'd0);
    RST = 1'b0;
    drive(1'b1, 1'b0, 1'b1);
    tick();
    chk_cyc("reset.noedge", 1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    tick();

    // Case 1: edge at 10, BUSY 15..40, ACK always
    for (int c = 0; c <= 55; c++) begin
      chk_cyc("c1", c, (c >= 11 && c <= 14), (c >= 42 && c <= 49), c - 42, c == 50, 1'b0, 1'b0);
      drive((c >= 10 && c <= 11), (c >= 15 && c <= 40), 1'b1);
      tick();
    end

    // Case 2: same plus a dropped edge at 20
    for (int c = 0; c <= 55; c++) begin
      chk_cyc("c2", c, (c >= 11 && c <= 14), (c >= 42 && c <= 49), c - 42, c == 50, c == 21, 1'b0);
      drive((c >= 10 && c <= 11) || (c >= 20 && c <= 21), (c >= 15 && c <= 40), 1'b1);
      tick();
    end

    // Case 3: BUSY stuck, edge coinciding with timeout, then a masked-BUSY conversion
    for (int c = 0; c <= 460; c++) begin
      chk_cyc("c3", c, (c >= 11 && c <= 14) || (c >= 431 && c <= 434), (c >= 438 && c <= 445),
              c - 438, c == 446, c == 416, c == 416);
      drive((c >= 10 && c <= 11) || (c >= 415 && c <= 420) || (c >= 430 && c <= 431),
            c <= 420, 1'b1);
      tick();
    end

    // Case 4: ACK every third cycle; second edge lands on the SAMPLE_DONE cycle
    xfers = 0;
    for (int c = 0; c <= 75; c++) begin
      chk_cyc("c4", c, (c >= 11 && c <= 14) || (c >= 41 && c <= 44),
              (c >= 18 && c <= 39) || (c >= 48 && c <= 69),
              (c - ((c < 45) ? 18 : 48) + 2) / 3, (c == 40) || (c == 70), 1'b0, 1'b0);
      drive((c >= 10 && c <= 11) || (c >= 40 && c <= 41), 1'b0, (c % 3) == 0);
      if (bus.RD_REQ && bus.RD_ACK) xfers++;
      tick();
    end
    chk("c4.xfers", 75, 32'(xfers), 32'd16);

    // Case 5: reset during READ at ch 3 with TRIG held high
    for (int c = 0; c <= 62; c++) begin
      chk_cyc("c5", c, (c >= 11 && c <= 14) || (c >= 44 && c <= 47),
              (c >= 18 && c <= 21) || (c >= 51 && c <= 58),
              c - ((c < 40) ? 18 : 51), c == 59, 1'b0, 1'b0);
      RST = (c == 21) || (c == 22);
      drive((c >= 10 && c <= 40) || (c >= 43), 1'b0, 1'b1);
      tick();
    end

    // Case 6: fresh reset, edges 20 cycles apart, stamps mod 16
    RST = 1'b1;
    drive(1'b0, 1'b0, 1'b1);
    repeat (2) tick();
    RST = 1'b0;
    for (int c = 0; c <= 70; c++) begin
      e = (c < 30) ? 10 : ((c < 50) ? 30 : 50);
      chk_cyc("c6", c, (c >= e + 1 && c <= e + 4), (c >= e + 8 && c <= e + 15),
              c - e - 8, c == e + 16, 1'b0, 1'b0);
`ifdef ADC_SCHED_TIMESTAMP_EN
      ts_exp = (c < 26) ? 0 : ((c < 46) ? 10 : ((c < 66) ? 14 : 2));
`else
      ts_exp = 0;
`endif
      chk("c6.ts", c, 32'(bus.TIMESTAMP), 32'(ts_exp));
      drive((c == 10) || (c == 11) || (c == 30) || (c == 31) || (c == 50) || (c == 51),
            1'b0, 1'b1);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
